sc_reg_universal_shift: RTL and testbench



---
 rtl/sc_reg_universal_pkg.sv | 15 +
 rtl/sc_shift_step.sv | 42 ++++
 rtl/sc_reg_universal_shift.sv | 105 ++++++++++
 tb/tb_sc_reg_universal_shift.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_reg_universal_pkg.sv
// Shared encodings for the universal shift register.
// Burst modes and the two-state burst controller.
package sc_reg_universal_pkg;

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sc_shift_step.sv
// One-bit shift/rotate step, purely combinational.
// Produces the next register value and the bit that leaves it.
module sc_shift_step
    import sc_reg_universal_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] i_data,
    input  logic [1:0]           i_mode,
    input  logic                 i_serial,
    output logic [DATAWIDTH-1:0] o_data,
    output logic                 o_bit
);

    always_comb begin
        o_data = i_data;
        o_bit  = 1'b0;
        case (i_mode)
            MODE_SHL: begin
                o_data = {i_data[DATAWIDTH-2:0], i_serial};
                o_bit  = i_data[DATAWIDTH-1];
            end
            MODE_SHR: begin
                o_data = {i_serial, i_data[DATAWIDTH-1:1]};
                o_bit  = i_data[0];
            end
            MODE_ROL: begin
                o_data = {i_data[DATAWIDTH-2:0], i_data[DATAWIDTH-1]};
                o_bit  = i_data[DATAWIDTH-1];
            end
            MODE_ROR: begin
                o_data = {i_data[0], i_data[DATAWIDTH-1:1]};
                o_bit  = i_data[0];
            end
            default: begin
                o_data = i_data;
                o_bit  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sc_reg_universal_shift.sv
// Loadable W-bit register with clear, reset value and a
// burst shift/rotate engine that takes one step per clock.
module sc_reg_universal_shift #(
    parameter int                  DATAWIDTH   = 8,
    parameter logic [DATAWIDTH-1:0] RESET_VALUE = DATAWIDTH'(15),
    parameter int                  CNTWIDTH    = $clog2(DATAWIDTH + 1)
) (
    input  logic                 SC_RegGENERAL_CLOCK_50,
    input  logic                 SC_RegGENERAL_RESET_InHigh,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [CNTWIDTH-1:0]  count_i,
    input  logic                 serial_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 serial_o,
    output logic                 busy_o,
    output logic                 done_o
);

    import sc_reg_universal_pkg::*;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_data;
    logic                 r_serial;
    logic                 r_busy;
    logic                 r_done;
    logic [CNTWIDTH-1:0]  r_remain;
    logic [1:0]           r_mode;

    logic [DATAWIDTH-1:0] w_next;
    logic                 w_bit;

    // The latched mode drives the stepper so mid-burst mode_i changes are inert
    sc_shift_step #(
        .DATAWIDTH (DATAWIDTH)
    ) u_step (
        .i_data   (r_data),
        .i_mode   (r_mode),
        .i_serial (serial_i),
        .o_data   (w_next),
        .o_bit    (w_bit)
    );

    always_ff @(posedge SC_RegGENERAL_CLOCK_50
                or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            r_state  <= IDLE;
            r_data   <= RESET_VALUE;
            r_serial <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_remain <= '0;
            r_mode   <= MODE_SHL;
        end else begin
            r_done <= 1'b0;
            if (clear_i) begin
                r_state  <= IDLE;
                r_data   <= '0;
                r_serial <= 1'b0;
                r_busy   <= 1'b0;
                r_remain <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load_i) begin
                            r_data <= data_i;
                        end else if (start_i) begin
                            r_mode <= mode_i;
                            if (count_i == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state  <= SHIFT;
                                r_busy   <= 1'b1;
                                r_remain <= count_i;
                            end
                        end
                    end
                    SHIFT: begin
                        r_data   <= w_next;
                        r_serial <= w_bit;
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == CNTWIDTH'(1)) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_o   = r_data;
    assign serial_o = r_serial;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_sc_reg_universal_shift.sv
// Directed and randomized bench for sc_reg_universal_shift,
// checked against an arithmetic model of the register.
module tb_sc_reg_universal_shift;

    localparam int W    = 8;
    localparam int CW   = $clog2(W + 1);
    localparam int MASK = (1 << W) - 1;
    localparam int RV   = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear_i = 1'b0;
    logic          load_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [CW-1:0] count_i = '0;
    logic          serial_i = 1'b0;
    logic [W-1:0]  data_o;
    logic          serial_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    int m_data, m_serial, m_busy, m_done, m_rem, m_mode;

    sc_reg_universal_shift #(
        .DATAWIDTH   (W),
        .RESET_VALUE (W'(RV))
    ) dut (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .clear_i  (clear_i),
        .load_i   (load_i),
        .data_i   (data_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .count_i  (count_i),
        .serial_i (serial_i),
        .data_o   (data_o),
        .serial_o (serial_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data   = RV;
        m_serial = 0;
        m_busy   = 0;
        m_done   = 0;
        m_rem    = 0;
        m_mode   = 0;
    endtask

    // Expected effect of one rising edge, from the current inputs
    task automatic model_edge();
        int d, f;
        d = m_data;
        f = int'(serial_i);
        m_done = 0;
        if (clear_i) begin
            m_data = 0; m_serial = 0; m_busy = 0; m_rem = 0;
        end else if (m_busy == 0) begin
            if (load_i) begin
                m_data = int'(data_i);
            end else if (start_i) begin
                m_mode = int'(mode_i);
                if (count_i == 0) m_done = 1;
                else begin
                    m_busy = 1;
                    m_rem  = int'(count_i);
                end
            end
        end else begin
            case (m_mode)
                0: begin
                    m_serial = (d >> (W - 1)) & 1;
                    m_data   = (d * 2 + f) & MASK;
                end
                1: begin
                    m_serial = d & 1;
                    m_data   = (d >> 1) + f * (1 << (W - 1));
                end
                2: begin
                    m_serial = (d >> (W - 1)) & 1;
                    m_data   = (d * 2 + ((d >> (W - 1)) & 1)) & MASK;
                end
                default: begin
                    m_serial = d & 1;
                    m_data   = (d >> 1) + (d & 1) * (1 << (W - 1));
                end
            endcase
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},   int'(data_o),   m_data);
        chk({tag, ".serial"}, int'(serial_o), m_serial);
        chk({tag, ".busy"},   int'(busy_o),   m_busy);
        chk({tag, ".done"},   int'(done_o),   m_done);
        chk({tag, ".excl"},   int'(busy_o & done_o), 0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic go(input int m, input int n, input bit s);
        mode_i   = 2'(m);
        count_i  = CW'(n);
        serial_i = s;
        start_i  = 1'b1;
        tick("start");
        start_i  = 1'b0;
    endtask

    task automatic ld(input int v);
        data_i = W'(v);
        load_i = 1'b1;
        tick("load");
        load_i = 1'b0;
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        model_reset();
        #2;
        check_all("por");
        chk("por.const", int'(data_o), 'h0F);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-burst, observed without a clock edge
        ld('h5A);
        go(0, 5, 1'b0);
        tick("mb1");
        tick("mb2");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.data",   int'(data_o),   'h0F);
        chk("arst.serial", int'(serial_o), 0);
        chk("arst.busy",   int'(busy_o),   0);
        chk("arst.done",   int'(done_o),   0);
        @(negedge clk);
        rst = 1'b0;

        // Shift left 0xA5 by 3
        ld('hA5);
        go(0, 3, 1'b0);
        chk("shl.busy0", int'(busy_o), 1);
        tick("shl1");
        chk("shl.d1", int'(data_o), 'h4A);
        tick("shl2");
        chk("shl.d2", int'(data_o), 'h94);
        tick("shl3");
        chk("shl.d3", int'(data_o), 'h28);
        chk("shl.so", int'(serial_o), 1);
        chk("shl.done", int'(done_o), 1);
        chk("shl.idle", int'(busy_o), 0);
        tick("shl4");
        chk("shl.pulse", int'(done_o), 0);

        // Rotate right 0x81 by 1, rotate left 0x3C by 8
        ld('h81);
        go(3, 1, 1'b0);
        tick("ror1");
        chk("ror.d", int'(data_o), 'hC0);
        chk("ror.so", int'(serial_o), 1);
        ld('h3C);
        go(2, 8, 1'b0);
        for (int i = 0; i < 7; i++) tick("rol");
        chk("rol.busy7", int'(busy_o), 1);
        tick("rol8");
        chk("rol.d", int'(data_o), 'h3C);
        chk("rol.done", int'(done_o), 1);

        // Shift right fill ones, then a zero-length burst
        ld('h00);
        go(1, 8, 1'b1);
        for (int i = 0; i < 8; i++) tick("shr");
        chk("shr.d", int'(data_o), 'hFF);
        tick("gap");
        go(0, 0, 1'b0);
        chk("n0.done", int'(done_o), 1);
        chk("n0.busy", int'(busy_o), 0);
        chk("n0.data", int'(data_o), 'hFF);
        tick("n0b");
        chk("n0.pulse", int'(done_o), 0);

        // Clear aborts a burst with no done pulse
        go(0, 5, 1'b0);
        tick("clr1");
        clear_i = 1'b1;
        tick("clr");
        clear_i = 1'b0;
        chk("clr.data", int'(data_o), 0);
        chk("clr.busy", int'(busy_o), 0);
        for (int i = 0; i < 4; i++) begin
            tick("clrq");
            chk("clr.nodone", int'(done_o), 0);
        end

        // Load ignored while busy, back-to-back burst from done cycle
        ld('h11);
        go(0, 4, 1'b0);
        data_i = 8'h55;
        load_i = 1'b1;
        tick("lb");
        load_i = 1'b0;
        chk("lb.data", int'(data_o), 'h22);
        tick("lb2");
        tick("lb3");
        tick("lb4");
        chk("lb.end", int'(data_o), 'h10);
        chk("lb.done", int'(done_o), 1);
        go(2, 2, 1'b0);
        chk("b2b.busy", int'(busy_o), 1);
        tick("b2b1");
        tick("b2b2");
        chk("b2b.d", int'(data_o), 'h40);

        // Load and start together: load wins
        data_i  = 8'h99;
        load_i  = 1'b1;
        mode_i  = 2'b00;
        count_i = CW'(3);
        start_i = 1'b1;
        tick("ls");
        load_i  = 1'b0;
        start_i = 1'b0;
        chk("ls.data", int'(data_o), 'h99);
        chk("ls.busy", int'(busy_o), 0);
        tick("ls2");
        chk("ls2.busy", int'(busy_o), 0);

        // Randomized traffic, including counts beyond W
        for (int i = 0; i < 600; i++) begin
            clear_i  = ($urandom_range(0, 39) == 0);
            load_i   = ($urandom_range(0, 7) == 0);
            start_i  = ($urandom_range(0, 2) == 0);
            data_i   = W'($urandom);
            mode_i   = 2'($urandom);
            count_i  = CW'($urandom);
            serial_i = 1'($urandom);
            tick("rnd");
        end
        clear_i = 1'b0;
        load_i  = 1'b0;
        start_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
